// File: rtl/uart_rx_byte_core_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_byte_core_pkg
// Shared constants and FSM encoding for the 8N1 UART byte receiver.
// ---------------------------------------------------------------------------
package uart_rx_byte_core_pkg;

  // Oversampling geometry: 16 ticks per bit, start bit checked at its middle.
  localparam int unsigned OVERSAMPLE  = 16;
  localparam int unsigned START_MID   = 7;
  localparam int unsigned SAMPLE_LAST = 15;
  localparam int unsigned SAMPLE_W    = 4;

  // Frame payload geometry.
  localparam int unsigned DATA_BITS   = 8;
  localparam int unsigned BIT_CNT_W   = 3;

  // Receiver FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  // Clocks per oversample tick, integer-truncated.
  function automatic int unsigned calc_divisor(input int unsigned clk_hz,
                                               input int unsigned baud);
    return clk_hz / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_oversample_tick_generator.sv
// ---------------------------------------------------------------------------
// uart_oversample_tick_generator
// Free-running divider that emits a one-clk pulse every DIVISOR clocks.
// The phase is never re-aligned to the serial line.
//
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous active-low reset
//   tick  - registered one-clk pulse, period DIVISOR clocks
// ---------------------------------------------------------------------------
module uart_oversample_tick_generator
  import uart_rx_byte_core_pkg::*;
#(
  parameter int unsigned DIVISOR = 2
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  // Divisor below 2 would leave no room for a tick-free clock between pulses.
  if (DIVISOR < 2) begin : g_bad_divisor
    $error("uart_oversample_tick_generator: DIVISOR must be >= 2");
  end

  localparam int unsigned CNT_W = (DIVISOR < 2) ? 1 : $clog2(DIVISOR);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVISOR - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Next count and tick pulse.
  always_comb begin
    cnt_d  = cnt_q + CNT_W'(1);
    tick_d = 1'b0;
    if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end
  end

  // Counter and tick registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/uart_rx_byte_core.sv
// ---------------------------------------------------------------------------
// uart_rx_byte_core
// 8N1, LSB-first UART receiver with 16x oversampling, glitch rejection on the
// start bit, sticky framing-error flag and break handling.
//
// Ports:
//   clk           - system clock, rising edge
//   reset         - asynchronous active-low reset
//   rx            - asynchronous serial line, idle high
//   rx_data       - last correctly framed byte, held until the next good one
//   rx_done_tick  - one-clk pulse in the clock rx_data updates
//   framing_error - sticky: last completed frame had a low stop bit
//   rx_busy       - high while a frame is in progress
// ---------------------------------------------------------------------------
module uart_rx_byte_core #(
  parameter int unsigned CLK_FREQ_HZ = 3200,
  parameter int unsigned BAUD_RATE   = 100,
  parameter int unsigned OVERSAMPLE  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done_tick,
  output logic       framing_error,
  output logic       rx_busy
);

  import uart_rx_byte_core_pkg::*;

  if (OVERSAMPLE != uart_rx_byte_core_pkg::OVERSAMPLE) begin : g_bad_oversample
    $error("uart_rx_byte_core: OVERSAMPLE is fixed at 16");
  end

  localparam int unsigned DIVISOR = calc_divisor(CLK_FREQ_HZ, BAUD_RATE);

  localparam logic [SAMPLE_W-1:0]  S_START_MID = SAMPLE_W'(START_MID);
  localparam logic [SAMPLE_W-1:0]  S_LAST      = SAMPLE_W'(SAMPLE_LAST);
  localparam logic [BIT_CNT_W-1:0] N_LAST      = BIT_CNT_W'(DATA_BITS - 1);

  // Oversample tick.
  logic tick;

  uart_oversample_tick_generator #(
    .DIVISOR (DIVISOR)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Line synchronizer and falling-edge detector.
  // vld_q tracks how far real line samples have propagated since reset, so the
  // reset value of the synchronizer (1) can never fake a falling edge when rx
  // is held low across reset release.
  logic       sync1_q, sync2_q;
  logic [1:0] vld_q;
  logic       prev_vld_q;
  logic       rx_prev_q;
  logic       rx_s;
  logic       fall_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      vld_q      <= 2'b00;
      prev_vld_q <= 1'b0;
      rx_prev_q  <= 1'b1;
    end else begin
      sync1_q    <= rx;
      sync2_q    <= sync1_q;
      vld_q      <= {vld_q[0], 1'b1};
      prev_vld_q <= vld_q[1];
      rx_prev_q  <= rx_s;
    end
  end

  assign rx_s   = sync2_q;
  assign fall_c = prev_vld_q & rx_prev_q & ~rx_s;

  // Receiver FSM and datapath state.
  rx_state_e            state_q, state_d;
  logic [SAMPLE_W-1:0]  s_q, s_d;
  logic [BIT_CNT_W-1:0] n_q, n_d;
  logic [7:0]           shift_q, shift_d;
  logic [7:0]           data_q, data_d;
  logic                 done_q, done_d;
  logic                 ferr_q, ferr_d;
  logic                 busy_q, busy_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = ferr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (fall_c) begin
          state_d = ST_START;
          s_d     = '0;
        end
      end

      // Re-check the line at the middle of the start bit to reject glitches.
      ST_START: begin
        if (tick) begin
          if (s_q == S_START_MID) begin
            if (!rx_s) begin
              state_d = ST_DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            s_d = s_q + SAMPLE_W'(1);
          end
        end
      end

      // Sample each data bit at its middle, LSB first.
      ST_DATA: begin
        if (tick) begin
          if (s_q == S_LAST) begin
            s_d     = '0;
            shift_d = {rx_s, shift_q[7:1]};
            if (n_q == N_LAST) begin
              state_d = ST_STOP;
            end else begin
              n_d = n_q + BIT_CNT_W'(1);
            end
          end else begin
            s_d = s_q + SAMPLE_W'(1);
          end
        end
      end

      // Commit the byte only on a high stop bit; leave at the stop midpoint so
      // a back-to-back start edge is seen from IDLE.
      ST_STOP: begin
        if (tick) begin
          if (s_q == S_LAST) begin
            state_d = ST_IDLE;
            if (rx_s) begin
              data_d = shift_q;
              done_d = 1'b1;
              ferr_d = 1'b0;
            end else begin
              ferr_d = 1'b1;
            end
          end else begin
            s_d = s_q + SAMPLE_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign rx_data       = data_q;
  assign rx_done_tick  = done_q;
  assign framing_error = ferr_q;
  assign rx_busy       = busy_q;

endmodule

// File: doc/uart_rx_byte_core.md
UART_RX_BYTE_CORE -- requirements
Module: uart_rx_byte_core

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 3200, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 100, serial bit rate.
REQ-003 Parameter OVERSAMPLE, default 16, oversample ticks per bit; fixed at 16.
REQ-004 clk  input  1  single system clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 rx  input  1  asynchronous serial line, 8N1, LSB first, idle high.
REQ-007 rx_data  output  8  last correctly framed byte, held until the next good frame; feeds integer_seven_segment_display_controller.integer_to_be_displayed.
REQ-008 rx_done_tick  output  1  one-clk pulse when rx_data updates.
REQ-009 framing_error  output  1  sticky flag: last frame had stop bit = 0.
REQ-010 rx_busy  output  1  high while a frame is in progress.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer; the synchronized value is used everywhere.
REQ-012 Oversample tick SHALL pulse one clk every DIVISOR = CLK_FREQ_HZ/(BAUD_RATE*16) clks, integer-truncated; DIVISOR < 2 is a parameter error.
REQ-013 Tick counter SHALL free-run from reset; it is not re-aligned on start-bit detection.
REQ-014 FSM states: IDLE, START, DATA, STOP.
REQ-015 IDLE: a synchronized falling edge (previous 1, current 0) SHALL move to START and clear the sample counter; a steady low SHALL NOT start a frame.
REQ-016 START: on each tick the sample counter increments; at count 7, rx=0 -> DATA (counters cleared), rx=1 -> IDLE (glitch rejected, no outputs change).
REQ-017 DATA: on each 16th tick, rx SHALL shift into an 8-bit register LSB first; after the 8th bit -> STOP.
REQ-018 STOP: on the 16th tick, rx=1 -> load rx_data from the shift register, pulse rx_done_tick, clear framing_error; rx=0 -> set framing_error, rx_data unchanged, no tick; both -> IDLE.
REQ-019 rx_done_tick SHALL assert in the clk after the tick at the stop-bit midpoint and last exactly one clk.
REQ-020 rx_busy SHALL be high in START, DATA and STOP, and low in IDLE.
REQ-021 After a framing error with rx held low (break), no new frame SHALL start until rx returns high and falls again.
REQ-022 Back-to-back frames with no idle gap SHALL all be received, because the falling edge of the next start bit occurs after the STOP->IDLE transition.

Reset
REQ-023 While reset=0: FSM=IDLE, counters=0, shift register=0, synchronizer flops=1, rx_data=8'd0, rx_done_tick=0, framing_error=0, rx_busy=0.
REQ-024 Reset asserted mid-frame SHALL abort the frame immediately, with no partial rx_data update.
REQ-025 After deassertion, the first frame SHALL begin only on a fresh falling edge.

Structure
REQ-026 A shared package SHALL hold the FSM state encoding, OVERSAMPLE=16, START_MID=7 and SAMPLE_LAST=15.
REQ-027 The divisor counter SHALL be the sub-module uart_oversample_tick_generator (clk, reset, tick); the FSM and datapath remain in uart_rx_byte_core.

Verification (CLK_FREQ_HZ=3200, BAUD_RATE=100 -> DIVISOR=2, 32 clk/bit)
REQ-028 Reset, then send 0x7B with a valid stop bit -> exactly one rx_done_tick; rx_data=0x7B (display 123); framing_error=0; rx_busy low afterwards.
REQ-029 Drive rx low for 8 clk, then high -> no rx_done_tick; rx_data unchanged; rx_busy returns to 0 within 20 clk.
REQ-030 Send 0xA5 with stop bit 0 -> framing_error=1, rx_data stays 0x7B, no tick; hold rx low for 5 bit times, then high, then send 0x01 -> rx_data=0x01, framing_error=0.
REQ-031 Send 0x00 then 0xFF with no idle gap -> two ticks, about 320 clk apart; rx_data=0x00 then 0xFF.
REQ-032 Assert reset during data bit 3 of 0x3C -> all outputs take their reset values immediately; after release, send 0x55 -> rx_data=0x55, one tick.
REQ-033 Hold rx low across reset release -> no frame starts until a high-to-low edge occurs.
